// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_sequencer
// Description : Timed four-phase traffic-light sequencer.
//               Cycles main-green (00), main-yellow (01), side-green (10) and
//               side-yellow (11), each held for a parameterised number of
//               cycles, and pulses phase_done in the first cycle of every new
//               phase.
//               Optional macro TLC_SENSOR_EN: main-green is held past its
//               minimum until side_car is seen, up to MAX_GREEN cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer #(
  parameter int MAIN_GREEN = 20,
  parameter int SIDE_GREEN = 10,
  parameter int YELLOW     = 3,
  parameter int MAX_GREEN  = 60,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       side_car,
  output logic [1:0] state,
  output logic       phase_done
);

  // Durations are compared as "last count" values so the counter never needs
  // to hold the duration itself; that is why a duration of exactly 2^CNT_W fits.
  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MAIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YL_LAST = CNT_W'(YELLOW - 1);

  // Reject parameter sets that would make a phase empty or overflow the counter.
  if (MAIN_GREEN < 1 || SIDE_GREEN < 1 || YELLOW < 1 ||
      MAIN_GREEN > (2 ** CNT_W) || SIDE_GREEN > (2 ** CNT_W) ||
      YELLOW > (2 ** CNT_W) || MAX_GREEN > (2 ** CNT_W) ||
      MAX_GREEN < MAIN_GREEN) begin : g_bad_params
    $error("traffic_phase_sequencer: illegal duration parameters");
  end

  typedef enum logic [1:0] {
    S0_MAIN_GREEN  = 2'b00,
    S1_MAIN_YELLOW = 2'b01,
    S2_SIDE_GREEN  = 2'b10,
    S3_SIDE_YELLOW = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_done_q, phase_done_d;
  logic             w_last;

`ifdef TLC_SENSOR_EN
  localparam logic [CNT_W-1:0] MX_LAST = CNT_W'(MAX_GREEN - 1);
  // Main green ends once the minimum is served and a side car waits,
  // or unconditionally at the maximum.
  logic w_s0_exit;
  assign w_s0_exit = ((cnt_q >= MG_LAST) && side_car) || (cnt_q == MX_LAST);
`else
  // Fixed timing: the sensor input plays no part.
  logic unused_side_car;
  logic w_s0_exit;
  assign unused_side_car = side_car;
  assign w_s0_exit       = (cnt_q == MG_LAST);
`endif

  // Decide whether this cycle is the last one of the current phase.
  always_comb begin
    w_last = 1'b0;
    case (state_q)
      S0_MAIN_GREEN:  w_last = w_s0_exit;
      S1_MAIN_YELLOW: w_last = (cnt_q == YL_LAST);
      S2_SIDE_GREEN:  w_last = (cnt_q == SG_LAST);
      S3_SIDE_YELLOW: w_last = (cnt_q == YL_LAST);
      default:        w_last = 1'b0;
    endcase
  end

  // Next-state: advance in fixed order, clear the counter and pulse on exit;
  // a disabled cycle freezes everything and suppresses the pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    phase_done_d = 1'b0;
    if (enable) begin
      if (w_last) begin
        cnt_d        = '0;
        phase_done_d = 1'b1;
        case (state_q)
          S0_MAIN_GREEN:  state_d = S1_MAIN_YELLOW;
          S1_MAIN_YELLOW: state_d = S2_SIDE_GREEN;
          S2_SIDE_GREEN:  state_d = S3_SIDE_YELLOW;
          default:        state_d = S0_MAIN_GREEN;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Phase state, counter and pulse registers; reset returns to start of s0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S0_MAIN_GREEN;
      cnt_q        <= '0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign state      = state_q;
  assign phase_done = phase_done_q;

endmodule
`default_nettype wire
